// File: rtl/eth_drp_arbiter.sv
// Two-requester arbiter for a single transceiver DRP port.
// Each requester posts a single-cycle strobe that is held as a pending
// request until the DRP transaction completes or times out. Grants
// alternate round-robin when both requesters are waiting.
//
// Handshake: reqN_en is a one-cycle strobe accepted only when no request
// from N is pending. reqN_rdy is a one-cycle strobe carrying reqN_do and,
// on a timeout, reqN_err. drp_en is a one-cycle strobe. drp_rdy is honoured
// only while waiting for a response and is ignored at all other times.
module eth_drp_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        xcvr_ctrl_clk,
  input  logic        xcvr_ctrl_rst_n,
  input  logic        req0_en,
  input  logic        req0_we,
  input  logic [9:0]  req0_addr,
  input  logic [15:0] req0_di,
  output logic [15:0] req0_do,
  output logic        req0_rdy,
  output logic        req0_err,
  input  logic        req1_en,
  input  logic        req1_we,
  input  logic [9:0]  req1_addr,
  input  logic [15:0] req1_di,
  output logic [15:0] req1_do,
  output logic        req1_rdy,
  output logic        req1_err,
  output logic        drp_en,
  output logic        drp_we,
  output logic [9:0]  drp_addr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_rdy,
  output logic [7:0]  timeout_count,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] ABORT_VAL = 16'hDEAD;

  logic [1:0]  rst_pipe;
  logic        rst_int_n;
  state_t      state;
  logic [1:0]  pending;
  logic        last;
  logic        gnt;
  logic [15:0] cnt;

  logic        p0_we;
  logic [9:0]  p0_addr;
  logic [15:0] p0_di;
  logic        p1_we;
  logic [9:0]  p1_addr;
  logic [15:0] p1_di;

  logic        done;
  logic        abort;
  logic        win;
  logic [1:0]  pend_set;
  logic [1:0]  pend_clr;

  // Reset asserts immediately and releases two clock edges later.
  always_ff @(posedge xcvr_ctrl_clk or negedge xcvr_ctrl_rst_n) begin
    if (!xcvr_ctrl_rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_int_n = rst_pipe[1];
  assign fsm_state = state;

  // Completion, abort, grant selection and pending set/clear decode.
  always_comb begin
    done     = 1'b0;
    abort    = 1'b0;
    win      = 1'b0;
    pend_set = 2'b00;
    pend_clr = 2'b00;
    if (state == WAIT) begin
      done  = drp_rdy;
      abort = !drp_rdy && (cnt == TMO_LAST);
    end
    // With both waiting, the one not served last wins; otherwise the sole one.
    win      = (&pending) ? ~last : pending[1];
    pend_set = {req1_en & ~pending[1], req0_en & ~pending[0]};
    if (done || abort) begin
      pend_clr = gnt ? 2'b10 : 2'b01;
    end
  end

  // Capture the request fields alongside the pending flag; a request
  // arriving while one is already pending leaves these untouched.
  always_ff @(posedge xcvr_ctrl_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      p0_we   <= 1'b0;
      p0_addr <= 10'd0;
      p0_di   <= 16'd0;
      p1_we   <= 1'b0;
      p1_addr <= 10'd0;
      p1_di   <= 16'd0;
    end else begin
      if (pend_set[0]) begin
        p0_we   <= req0_we;
        p0_addr <= req0_addr;
        p0_di   <= req0_di;
      end
      if (pend_set[1]) begin
        p1_we   <= req1_we;
        p1_addr <= req1_addr;
        p1_di   <= req1_di;
      end
    end
  end

  // Arbitration FSM with all DRP and completion outputs registered.
  always_ff @(posedge xcvr_ctrl_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state         <= IDLE;
      pending       <= 2'b00;
      last          <= 1'b1;
      gnt           <= 1'b0;
      cnt           <= 16'd0;
      drp_en        <= 1'b0;
      drp_we        <= 1'b0;
      drp_addr      <= 10'd0;
      drp_di        <= 16'd0;
      req0_do       <= 16'd0;
      req0_rdy      <= 1'b0;
      req0_err      <= 1'b0;
      req1_do       <= 16'd0;
      req1_rdy      <= 1'b0;
      req1_err      <= 1'b0;
      timeout_count <= 8'd0;
    end else begin
      req0_rdy <= 1'b0;
      req0_err <= 1'b0;
      req1_rdy <= 1'b0;
      req1_err <= 1'b0;
      pending  <= (pending | pend_set) & ~pend_clr;
      case (state)
        IDLE: begin
          if (|pending) begin
            gnt      <= win;
            drp_we   <= win ? p1_we   : p0_we;
            drp_addr <= win ? p1_addr : p0_addr;
            drp_di   <= win ? p1_di   : p0_di;
            drp_en   <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          drp_en <= 1'b0;
          cnt    <= 16'd0;
          state  <= WAIT;
        end
        WAIT: begin
          if (done || abort) begin
            // A response on the timeout cycle itself counts as completion.
            if (gnt) begin
              req1_do  <= done ? drp_do : ABORT_VAL;
              req1_rdy <= 1'b1;
              req1_err <= abort;
            end else begin
              req0_do  <= done ? drp_do : ABORT_VAL;
              req0_rdy <= 1'b1;
              req0_err <= abort;
            end
            if (abort && (timeout_count != 8'hFF)) begin
              timeout_count <= timeout_count + 8'd1;
            end
            last  <= gnt;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_drp_arbiter.sv
// Bench for eth_drp_arbiter: randomized and directed requests, a DRP
// responder with a register array, and a per-requester scoreboard.
module tb_eth_drp_arbiter;

  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req0_en = 1'b0, req0_we = 1'b0;
  logic [9:0]  req0_addr = '0;
  logic [15:0] req0_di = '0;
  logic [15:0] req0_do;
  logic        req0_rdy, req0_err;
  logic        req1_en = 1'b0, req1_we = 1'b0;
  logic [9:0]  req1_addr = '0;
  logic [15:0] req1_di = '0;
  logic [15:0] req1_do;
  logic        req1_rdy, req1_err;
  logic        drp_en, drp_we;
  logic [9:0]  drp_addr;
  logic [15:0] drp_di;
  logic [15:0] drp_do = '0;
  logic        drp_rdy = 1'b0;
  logic [7:0]  timeout_count;
  logic [1:0]  fsm_state;

  eth_drp_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .xcvr_ctrl_clk(clk), .xcvr_ctrl_rst_n(rst_n),
    .req0_en(req0_en), .req0_we(req0_we), .req0_addr(req0_addr), .req0_di(req0_di),
    .req0_do(req0_do), .req0_rdy(req0_rdy), .req0_err(req0_err),
    .req1_en(req1_en), .req1_we(req1_we), .req1_addr(req1_addr), .req1_di(req1_di),
    .req1_do(req1_do), .req1_rdy(req1_rdy), .req1_err(req1_err),
    .drp_en(drp_en), .drp_we(drp_we), .drp_addr(drp_addr), .drp_di(drp_di),
    .drp_do(drp_do), .drp_rdy(drp_rdy),
    .timeout_count(timeout_count), .fsm_state(fsm_state)
  );

  // ---------------- reference model state ----------------
  logic [15:0] ref_mem [1024];
  logic [15:0] dev_mem [1024];
  logic [16:0] exp_q0 [$];
  logic [16:0] exp_q1 [$];
  bit          busy [2];
  logic        iss_we [2];
  logic [9:0]  iss_addr [2];
  logic [15:0] iss_di [2];
  int          tmo_exp = 0;
  int          delay_ovr = 0;
  int          checks = 0;
  int          failures = 0;
  int          gnt_log [$];
  int          drp_en_cnt = 0;
  int          last_en_cyc = 0;
  int          last_drp_rdy_cyc = 0;
  int          rdy_cnt [2];
  int          last_rdy_cyc [2];

  // Responder latency in cycles after drp_en (cycle of drp_rdy minus cycle of drp_en).
  function automatic int eff_delay(input logic [9:0] a);
    if (delay_ovr != 0) return delay_ovr;
    return int'(a[3:0]) + 1 + (a[4] ? 2 : 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model side of a request: a requester already waiting is ignored; otherwise the
  // outcome is decided by whether the responder answers within the timeout window.
  task automatic model_issue(input int n, input logic we, input logic [9:0] a, input logic [15:0] d);
    logic [15:0] data;
    bit tmo;
    if (busy[n]) return;
    tmo  = eff_delay(a) > TMO;
    data = tmo ? 16'hDEAD : (we ? d : ref_mem[a]);
    if (we) ref_mem[a] = d;
    if (n == 0) exp_q0.push_back({tmo, data});
    else        exp_q1.push_back({tmo, data});
    busy[n]     = 1'b1;
    iss_we[n]   = we;
    iss_addr[n] = a;
    iss_di[n]   = d;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic e0, input logic w0, input logic [9:0] a0, input logic [15:0] d0,
                      input logic e1, input logic w1, input logic [9:0] a1, input logic [15:0] d1);
    @(negedge clk);
    #1;
    req0_en = e0; req0_we = w0; req0_addr = a0; req0_di = d0;
    req1_en = e1; req1_we = w1; req1_addr = a1; req1_di = d1;
    if (e0) model_issue(0, w0, a0, d0);
    if (e1) model_issue(1, w1, a1, d1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 10'd0, 16'd0);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy[0] || busy[1]) && k < budget) begin
      idle(1);
      k++;
    end
    if (busy[0] || busy[1]) begin
      checks++;
      failures++;
      $display("FAIL wait_idle no completion within %0d cycles (cycle %0d)", budget, cyc);
      exp_q0.delete();
      exp_q1.delete();
      busy[0] = 1'b0;
      busy[1] = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_drp_en"}, drp_en, 0);
    check({tag, "_drp_we"}, drp_we, 0);
    check({tag, "_drp_addr"}, drp_addr, 0);
    check({tag, "_drp_di"}, drp_di, 0);
    check({tag, "_req0_do"}, req0_do, 0);
    check({tag, "_req0_rdy"}, req0_rdy, 0);
    check({tag, "_req0_err"}, req0_err, 0);
    check({tag, "_req1_do"}, req1_do, 0);
    check({tag, "_req1_rdy"}, req1_rdy, 0);
    check({tag, "_req1_err"}, req1_err, 0);
    check({tag, "_timeout_count"}, timeout_count, 0);
  endtask

  // ---------------- DRP responder ----------------
  int          cd = 0;
  logic        prev_en = 1'b0;
  logic [9:0]  lat_addr;
  logic [15:0] lat_di;
  logic [15:0] resp;
  always @(negedge clk) begin
    if (!rst_n) begin
      cd = 0;
      drp_rdy = 1'b0;
      prev_en = 1'b0;
    end else begin
      drp_rdy = 1'b0;
      drp_do  = 16'($urandom);
      if (drp_en) begin
        int id;
        id = int'(drp_addr[9]);
        check("drp_en_single_cycle", prev_en, 0);
        drp_en_cnt++;
        last_en_cyc = cyc;
        gnt_log.push_back(id);
        check("drp_grant_has_request", busy[id], 1);
        check("drp_addr", drp_addr, iss_addr[id]);
        check("drp_we", drp_we, iss_we[id]);
        check("drp_di", drp_di, iss_di[id]);
        lat_addr = drp_addr;
        lat_di   = drp_di;
        resp     = drp_we ? drp_di : dev_mem[drp_addr];
        if (drp_we) dev_mem[drp_addr] = drp_di;
        cd = eff_delay(drp_addr);
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          drp_rdy = 1'b1;
          drp_do  = resp;
          last_drp_rdy_cyc = cyc;
          check("drp_addr_stable", drp_addr, lat_addr);
          check("drp_di_stable", drp_di, lat_di);
        end
      end
      prev_en = drp_en;
    end
  end

  // ---------------- scoreboard monitor ----------------
  task automatic mon(input int n, input logic rdy, input logic err, input logic [15:0] dout);
    logic [16:0] e;
    if (!rdy) begin
      if (err) begin
        checks++;
        failures++;
        $display("FAIL req%0d_err_without_rdy actual=1 required=0 (cycle %0d)", n, cyc);
      end
      return;
    end
    rdy_cnt[n]++;
    last_rdy_cyc[n] = cyc;
    if ((n == 0 && exp_q0.size() == 0) || (n == 1 && exp_q1.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL req%0d_unexpected_rdy actual=1 required=0 (cycle %0d)", n, cyc);
      return;
    end
    e = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    check($sformatf("req%0d_do", n), dout, e[15:0]);
    check($sformatf("req%0d_err", n), err, e[16]);
    if (e[16] && tmo_exp < 255) tmo_exp++;
    check("timeout_count", timeout_count, tmo_exp);
    busy[n] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, req0_rdy, req0_err, req0_do);
      mon(1, req1_rdy, req1_err, req1_do);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    int c0;
    int r0;
    int r1;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 16'($urandom);
      dev_mem[i] = ref_mem[i];
    end
    ref_mem[10'h07C] = 16'h1234;
    dev_mem[10'h07C] = 16'h1234;
    rdy_cnt[0] = 0; rdy_cnt[1] = 0;
    last_rdy_cyc[0] = 0; last_rdy_cyc[1] = 0;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // Simultaneous pair after reset: req0 first, then req1; again for the repeat pair.
    delay_ovr = 4;
    gnt_log.delete();
    step(1'b1, 1'b0, 10'h010, 16'd0, 1'b1, 1'b0, 10'h210, 16'd0);
    wait_idle(100);
    step(1'b1, 1'b0, 10'h020, 16'd0, 1'b1, 1'b0, 10'h220, 16'd0);
    wait_idle(100);
    check("pair_log_len", gnt_log.size(), 4);
    if (gnt_log.size() == 4) begin
      check("pair1_first", gnt_log[0], 0);
      check("pair1_second", gnt_log[1], 1);
      check("pair2_first", gnt_log[2], 0);
      check("pair2_second", gnt_log[3], 1);
    end

    // Single req0 read of 0x07C, responder answers 3 cycles after drp_en.
    delay_ovr = 3;
    r1 = rdy_cnt[1];
    step(1'b1, 1'b0, 10'h07C, 16'd0, 1'b0, 1'b0, 10'd0, 16'd0);
    t0 = cyc;
    wait_idle(50);
    check("single_drp_en_latency", last_en_cyc - t0, 2);
    check("single_rdy_after_drp_rdy", last_rdy_cyc[0] - last_drp_rdy_cyc, 1);
    check("single_rdy_after_drp_en", last_rdy_cyc[0] - last_en_cyc, 4);
    idle(3);
    check("single_req0_do_held", req0_do, 16'h1234);
    check("single_req1_untouched", rdy_cnt[1] - r1, 0);

    // Second req0_en while pending is ignored.
    delay_ovr = 6;
    c0 = drp_en_cnt;
    step(1'b1, 1'b1, 10'h055, 16'hAAAA, 1'b0, 1'b0, 10'd0, 16'd0);
    step(1'b1, 1'b1, 10'h066, 16'h5555, 1'b0, 1'b0, 10'd0, 16'd0);
    wait_idle(50);
    idle(4);
    check("dup_drp_en_count", drp_en_cnt - c0, 1);
    check("dup_req0_do", req0_do, 16'hAAAA);

    // req1 timeout; the responder answers late, in IDLE.
    delay_ovr = 20;
    r1 = rdy_cnt[1];
    step(1'b0, 1'b0, 10'd0, 16'd0, 1'b1, 1'b0, 10'h2A0, 16'd0);
    wait_idle(100);
    check("tmo_rdy_latency", last_rdy_cyc[1] - last_en_cyc, TMO + 1);
    check("tmo_req1_do", req1_do, 16'hDEAD);
    check("tmo_count_one", timeout_count, 1);
    idle(8);
    check("tmo_late_rdy_ignored", rdy_cnt[1] - r1, 1);
    delay_ovr = 2;
    step(1'b0, 1'b0, 10'd0, 16'd0, 1'b1, 1'b0, 10'h2A0, 16'd0);
    wait_idle(50);

    // Randomized traffic; per-address responder latency straddles the timeout.
    delay_ovr = 0;
    repeat (600) begin
      logic e0, e1;
      e0 = ($urandom_range(0, 3) == 0);
      e1 = ($urandom_range(0, 3) == 0);
      step(e0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 511)), 16'($urandom),
           e1, 1'($urandom_range(0, 1)), 10'(512 + $urandom_range(0, 511)), 16'($urandom));
    end
    wait_idle(200);

    // Forced timeouts until the counter saturates.
    delay_ovr = 1000;
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) step(1'b1, 1'b0, 10'(i % 512), 16'd0, 1'b0, 1'b0, 10'd0, 16'd0);
      else            step(1'b0, 1'b0, 10'd0, 16'd0, 1'b1, 1'b0, 10'(512 + i % 512), 16'd0);
      wait_idle(60);
    end
    check("timeout_count_saturated", timeout_count, 255);

    // Reset while waiting for a DRP response.
    delay_ovr = 12;
    r0 = rdy_cnt[0];
    step(1'b1, 1'b0, 10'h011, 16'd0, 1'b0, 1'b0, 10'd0, 16'd0);
    idle(6);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    busy[0] = 1'b0;
    busy[1] = 1'b0;
    tmo_exp = 0;
    #1;
    check_zero("midreset");
    idle(20);
    check_zero("midreset_hold");
    check("midreset_no_rdy", rdy_cnt[0] - r0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    delay_ovr = 5;
    step(1'b1, 1'b0, 10'h033, 16'd0, 1'b0, 1'b0, 10'd0, 16'd0);
    wait_idle(50);
    check("post_reset_completion", rdy_cnt[0] - r0, 1);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
